ttl_counter_updown_mod: RTL



---
 rtl/ttl_counter_updown_mod.sv | 86 ++++++++
 1 files changed

// File: rtl/ttl_counter_updown_mod.sv
// ttl_counter_updown_mod: synchronous up/down modulo-N counter with parallel
// load, ENT/ENP count enables, combinational ripple carry/borrow (RCO) and a
// registered one-cycle Wrap pulse after each terminal wrap.
module ttl_counter_updown_mod #(
  parameter int unsigned     WIDTH      = 4,
  parameter longint unsigned MODULUS    = 16,
  parameter int              DELAY_RISE = 0,
  parameter int              DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Load_bar,
  input  logic             ENT,
  input  logic             ENP,
  input  logic             Up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             Wrap
);

  // Computed in 64 bits so WIDTH=32 / MODULUS=2**32 does not overflow.
  localparam longint unsigned MAX_MOD = 64'd1 << WIDTH;

  // Reject illegal configurations at elaboration; the delay parameters are
  // carried only for interface compatibility with the older library cells.
  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > MAX_MOD ||
      DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    $error("ttl_counter_updown_mod: illegal WIDTH/MODULUS/DELAY parameters");
  end

  // Terminal count, and the modulus widened by one bit so the load
  // saturation compare stays exact when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             at_top;
  logic             at_zero;
  logic             count_en;
  logic [WIDTH-1:0] load_val;

  assign at_top   = (q == TOP);
  assign at_zero  = (q == '0);
  assign count_en = ENT & ENP;
  assign load_val = ({1'b0, D} >= MOD_EXT) ? TOP : D;

  // Count/load register with Clear > Load > Count > Hold priority.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (!Load_bar) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (count_en) begin
      if (Up) begin
        if (at_top) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          q    <= q + ONE;
          wrap <= 1'b0;
        end
      end else begin
        if (at_zero) begin
          q    <= TOP;
          wrap <= 1'b1;
        end else begin
          q    <= q - ONE;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign Q    = q;
  assign Wrap = wrap;
  // Ripple carry/borrow: ENT gates it, ENP deliberately does not.
  assign RCO  = ENT & (Up ? at_top : at_zero);

endmodule
